// File: rtl/cdr_loop_filter.sv
// Purpose : second-order bang-bang CDR loop filter that drives the phase interpolator code.
// Latency : one cycle from the vote that closes a window (or a code_load) to the refreshed Code.
// Backpres: none. One vote is accepted per cycle; en=0 freezes the loop, and code_load still works.
//
// Ports:
//   CLK, rst            loop clock, asynchronous active-high reset
//   en                  loop enable (0 = freeze votes, accumulators, lock state and Code)
//   pd_valid/up/dn      bang-bang phase detector vote (up = advance, dn = retard)
//   code_load/init      preset the phase accumulator to {code_init, 0 fraction}
//   Code, code_upd      interpolator code and its one-cycle refresh strobe
//   freq_word           signed integral-path (frequency) accumulator
//   locked              high after LOCK_N consecutive quiet decision windows
module cdr_loop_filter #(
   parameter int DECIM      = 4,
   parameter int KP         = 2,
   parameter int KI         = 1,
   parameter int FRAC_BITS  = 8,
   parameter int FREQ_WIDTH = 16,
   parameter int LOCK_TH    = 1,
   parameter int LOCK_N     = 8
) (
   input  logic                         CLK,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         pd_valid,
   input  logic                         pd_up,
   input  logic                         pd_dn,
   input  logic                         code_load,
   input  logic [10:0]                  code_init,
   output logic [10:0]                  Code,
   output logic                         code_upd,
   output logic signed [FREQ_WIDTH-1:0] freq_word,
   output logic                         locked
);

   localparam int CW   = $clog2(DECIM);
   localparam int NW   = CW + 2;
   localparam int PW   = 11 + FRAC_BITS;
   localparam int LW   = $clog2(LOCK_N + 1);
   localparam int FMAX = (2 ** (FREQ_WIDTH - 1)) - 1;

   logic [CW-1:0]                cnt_q, cnt_d;
   logic signed [NW-1:0]         net_q, net_d;
   logic signed [FREQ_WIDTH-1:0] freq_q, freq_d;
   logic [PW-1:0]                phase_q, phase_d;
   logic [LW-1:0]                lock_cnt_q, lock_cnt_d;
   logic                         locked_q, locked_d;
   logic                         upd_q, upd_d;

   logic                         vote_act;
   logic                         close;
   logic signed [NW-1:0]         v;
   logic signed [NW-1:0]         total;
   logic [NW-1:0]                abs_total;
   logic signed [1:0]            s;
   logic signed [31:0]           fsum;
   logic signed [FREQ_WIDTH-1:0] freq_new;
   logic signed [31:0]           delta;
   logic [PW-1:0]                phase_new;

   always_comb begin
      vote_act = en & pd_valid;
      close    = vote_act && (cnt_q == CW'(DECIM - 1));

      // Both or neither vote is a neutral vote; it still counts toward the window.
      v = '0;
      if (pd_up && !pd_dn) begin
         v = NW'(1);
      end else if (pd_dn && !pd_up) begin
         v = '1;
      end

      // The closing vote is folded into the decision.
      total     = net_q + v;
      abs_total = total[NW-1] ? NW'(-total) : NW'(total);

      s = 2'b00;
      if (total > 0) begin
         s = 2'b01;
      end else if (total < 0) begin
         s = 2'b11;
      end

      // The integral path saturates symmetrically instead of wrapping.
      fsum = 32'(freq_q) + (KI * 32'(s));
      if (fsum > FMAX) begin
         freq_new = FREQ_WIDTH'(FMAX);
      end else if (fsum < -FMAX) begin
         freq_new = FREQ_WIDTH'(-FMAX);
      end else begin
         freq_new = fsum[FREQ_WIDTH-1:0];
      end

      // The phase wraps modulo 2^PW: the interpolator is circular.
      delta     = ((KP * 32'(s)) <<< FRAC_BITS) + 32'(freq_new);
      phase_new = phase_q + delta[PW-1:0];
   end

   always_comb begin
      cnt_d      = cnt_q;
      net_d      = net_q;
      freq_d     = freq_q;
      phase_d    = phase_q;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      upd_d      = 1'b0;

      if (code_load) begin
         // A load overrides a coincident window close, whose decision is dropped.
         phase_d    = {code_init, {FRAC_BITS{1'b0}}};
         cnt_d      = '0;
         net_d      = '0;
         lock_cnt_d = '0;
         locked_d   = 1'b0;
         upd_d      = 1'b1;
      end else if (close) begin
         freq_d  = freq_new;
         phase_d = phase_new;
         cnt_d   = '0;
         net_d   = '0;
         if (32'(abs_total) <= LOCK_TH) begin
            if (lock_cnt_q != LW'(LOCK_N)) begin
               lock_cnt_d = lock_cnt_q + LW'(1);
            end
         end else begin
            lock_cnt_d = '0;
         end
         locked_d = (lock_cnt_d == LW'(LOCK_N));
         upd_d    = 1'b1;
      end else if (vote_act) begin
         cnt_d = cnt_q + CW'(1);
         net_d = total;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         net_q      <= '0;
         freq_q     <= '0;
         phase_q    <= '0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         upd_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         net_q      <= net_d;
         freq_q     <= freq_d;
         phase_q    <= phase_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         upd_q      <= upd_d;
      end
   end

   assign Code      = phase_q[PW-1:FRAC_BITS];
   assign code_upd  = upd_q;
   assign freq_word = freq_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Purpose : self-checking bench for cdr_loop_filter (directed scenarios plus random votes).
// Latency : outputs compared 1 time unit after each active clock edge.
// Backpres: not applicable; the bench drives one input set per cycle.
module tb_cdr_loop_filter;

   localparam int     DECIM   = 4;
   localparam int     KP      = 2;
   localparam int     KI      = 1;
   localparam int     FRAC    = 8;
   localparam int     FW      = 16;
   localparam int     LOCK_TH = 1;
   localparam int     LOCK_N  = 8;
   localparam longint PMOD    = longint'(1) << (11 + FRAC);
   localparam longint FMAX    = 32767;

   // Small second instance for exercising saturation in a short run.
   localparam int     S_DECIM = 2;
   localparam int     S_FW    = 6;
   localparam int     S_FMAX  = 31;

   logic CLK = 1'b0;
   logic rst = 1'b1;
   always #5 CLK = ~CLK;

   logic                 en = 1'b0, pd_valid = 1'b0, pd_up = 1'b0, pd_dn = 1'b0, code_load = 1'b0;
   logic [10:0]          code_init = '0;
   logic [10:0]          Code;
   logic                 code_upd;
   logic signed [FW-1:0] freq_word;
   logic                 locked;

   logic                   s_en = 1'b0, s_valid = 1'b0, s_up = 1'b0, s_dn = 1'b0;
   logic [10:0]            s_code;
   logic                   s_upd;
   logic signed [S_FW-1:0] s_freq;
   logic                   s_locked;

   cdr_loop_filter #(.DECIM(DECIM), .KP(KP), .KI(KI), .FRAC_BITS(FRAC), .FREQ_WIDTH(FW),
                     .LOCK_TH(LOCK_TH), .LOCK_N(LOCK_N)) u_dut (
      .CLK(CLK), .rst(rst), .en(en), .pd_valid(pd_valid), .pd_up(pd_up), .pd_dn(pd_dn),
      .code_load(code_load), .code_init(code_init), .Code(Code), .code_upd(code_upd),
      .freq_word(freq_word), .locked(locked));

   cdr_loop_filter #(.DECIM(S_DECIM), .FREQ_WIDTH(S_FW)) u_sat (
      .CLK(CLK), .rst(rst), .en(s_en), .pd_valid(s_valid), .pd_up(s_up), .pd_dn(s_dn),
      .code_load(1'b0), .code_init(11'd0), .Code(s_code), .code_upd(s_upd),
      .freq_word(s_freq), .locked(s_locked));

   int    n_chk  = 0;
   int    n_fail = 0;
   string phase_name = "init";

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s/%s observed=%0d expected=%0d at %0t", phase_name, tag, obs, exp, $time);
      end
   endtask

   // Reference model: the phase as an integer modulo PMOD, the frequency as a clamped
   // integer, the current window as a list of votes, and a run length of quiet windows.
   longint m_phase, m_freq;
   int     m_votes[$];
   int     m_quiet;
   bit     m_upd;

   task automatic model_reset();
      m_phase = 0; m_freq = 0; m_votes.delete(); m_quiet = 0; m_upd = 0;
   endtask

   task automatic model_step(input bit e, input bit vld, input bit up, input bit dn,
                             input bit ld, input logic [10:0] init);
      int v, tot, s;
      m_upd = 0;
      if (ld) begin
         m_phase = longint'(init) * 256;
         m_votes.delete();
         m_quiet = 0;
         m_upd   = 1;
      end else if (e && vld) begin
         v = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
         m_votes.push_back(v);
         if (m_votes.size() == DECIM) begin
            tot = m_votes.sum();
            s   = (tot > 0) ? 1 : ((tot < 0) ? -1 : 0);
            m_freq = m_freq + KI * s;
            if (m_freq > FMAX)  m_freq = FMAX;
            if (m_freq < -FMAX) m_freq = -FMAX;
            m_phase = ((m_phase + longint'(KP * s) * 256 + m_freq) % PMOD + PMOD) % PMOD;
            if (((tot < 0) ? -tot : tot) <= LOCK_TH) m_quiet++;
            else m_quiet = 0;
            m_upd = 1;
            m_votes.delete();
         end
      end
   endtask

   task automatic check_all();
      chk("code",   longint'(Code), m_phase / 256);
      chk("upd",    longint'(code_upd), longint'(m_upd));
      chk("freq",   longint'(freq_word), m_freq);
      chk("locked", longint'(locked), longint'(m_quiet >= LOCK_N));
   endtask

   task automatic cyc(input bit e, input bit vld, input bit up, input bit dn,
                      input bit ld, input logic [10:0] init);
      @(negedge CLK);
      en = e; pd_valid = vld; pd_up = up; pd_dn = dn; code_load = ld; code_init = init;
      @(posedge CLK);
      model_step(e, vld, up, dn, ld, init);
      #1;
      check_all();
   endtask

   task automatic votes(input int n, input bit up, input bit dn);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, up, dn, 1'b0, 11'd0);
   endtask

   // Reset is raised mid-cycle so its asynchronous effect is observed before any edge.
   task automatic do_reset();
      @(negedge CLK);
      en = 0; pd_valid = 0; pd_up = 0; pd_dn = 0; code_load = 0;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge CLK);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();

      phase_name = "reset";
      do_reset();

      phase_name = "ups";
      votes(4, 1, 0);
      chk("tp_code2", longint'(Code), 2);
      chk("tp_freq1", longint'(freq_word), 1);
      cyc(1, 0, 0, 0, 0, 11'd0);
      votes(4, 1, 0);
      chk("tp_code4", longint'(Code), 4);
      chk("tp_freq2", longint'(freq_word), 2);

      phase_name = "fwd_wrap";
      do_reset();
      cyc(0, 0, 0, 0, 1, 11'd2047);
      chk("tp_load", longint'(Code), 2047);
      votes(4, 1, 0);
      chk("tp_wrap1", longint'(Code), 1);

      phase_name = "rev_wrap";
      do_reset();
      votes(4, 0, 1);
      chk("tp_code2045", longint'(Code), 2045);
      chk("tp_freqm1", longint'(freq_word), -1);

      phase_name = "lock";
      do_reset();
      for (int w = 0; w < 8; w++) begin
         votes(1, 1, 0); votes(1, 0, 1); votes(1, 1, 0); votes(1, 0, 1);
      end
      chk("tp_locked", longint'(locked), 1);
      chk("tp_code0", longint'(Code), 0);
      votes(4, 1, 0);
      chk("tp_unlock", longint'(locked), 0);
      chk("tp_code2b", longint'(Code), 2);

      phase_name = "freeze";
      for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, 11'd0);
      chk("tp_frz_code", longint'(Code), 2);
      votes(2, 1, 0);
      chk("tp_no_upd", longint'(code_upd), 0);

      phase_name = "mid_reset";
      do_reset();
      votes(2, 1, 0);
      do_reset();
      votes(4, 1, 0);
      chk("tp_rst_code", longint'(Code), 2);
      votes(3, 1, 0);
      cyc(1, 1, 1, 0, 1, 11'd700);
      chk("tp_ld_code", longint'(Code), 700);
      chk("tp_ld_freq", longint'(freq_word), 1);

      phase_name = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
             1'($urandom), ($urandom_range(0, 63) == 0), 11'($urandom));
      end

      // Saturation on the small instance: each all-up window adds one LSB until the limit.
      phase_name = "saturate";
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         for (int j = 0; j < S_DECIM; j++) begin
            @(negedge CLK);
            s_en = 1; s_valid = 1; s_up = 1; s_dn = 0;
         end
         @(posedge CLK); #1;
         chk("sat_upd", longint'(s_upd), 1);
         chk("sat_freq", longint'(s_freq), (k < S_FMAX) ? k : S_FMAX);
      end
      for (int j = 0; j < S_DECIM; j++) begin
         @(negedge CLK);
         s_up = 0; s_dn = 1;
      end
      @(posedge CLK); #1;
      chk("sat_back", longint'(s_freq), S_FMAX - 1);
      @(negedge CLK);
      s_en = 0; s_valid = 0; s_dn = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
